// File: rtl/score_bcd_display_pkg.sv
// Shared constants and helpers for the BCD score display block.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // 100 MHz board: 100000 clocks per digit, i.e. 1 ms per digit.
  localparam int DEFAULT_STROBE_MAX = 99999;
  localparam int DEFAULT_STROBE_WIDTH = 17;

  function automatic int sel_width_for(input int num_digits);
    int w;
    w = 1;
    while ((1 << w) < num_digits) w++;
    return w;
  endfunction

endpackage

// File: rtl/score_bcd_display_if.sv
// Collision-side inputs and display-side outputs of score_bcd_display.
// Optional high-score signals exist only with SCORE_HIGH_SCORE_EN.
interface score_bcd_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_WIDTH  = 2
);
  // No valid/ready: TARGET_ATE is a level whose rising edge scores a point,
  // GAME_RESTART is a one-cycle-effective synchronous clear, and all outputs
  // are continuously valid and sampled freely by the seg7 driver.
  logic                    TARGET_ATE;
  logic                    GAME_RESTART;
  logic [SEL_WIDTH-1:0]    STROBE_COUNT;
  logic [3:0]              SCORE_COUNT;
  logic [4*NUM_DIGITS-1:0] SCORE_BCD;
  logic                    SATURATED;
`ifdef SCORE_HIGH_SCORE_EN
  logic                    SHOW_HIGH;
  logic [4*NUM_DIGITS-1:0] HIGH_BCD;

  modport master (output TARGET_ATE, output GAME_RESTART, output SHOW_HIGH,
                  input STROBE_COUNT, input SCORE_COUNT, input SCORE_BCD,
                  input SATURATED, input HIGH_BCD);
  modport slave  (input TARGET_ATE, input GAME_RESTART, input SHOW_HIGH,
                  output STROBE_COUNT, output SCORE_COUNT, output SCORE_BCD,
                  output SATURATED, output HIGH_BCD);
`else
  modport master (output TARGET_ATE, output GAME_RESTART,
                  input STROBE_COUNT, input SCORE_COUNT, input SCORE_BCD,
                  input SATURATED);
  modport slave  (input TARGET_ATE, input GAME_RESTART,
                  output STROBE_COUNT, output SCORE_COUNT, output SCORE_BCD,
                  output SATURATED);
`endif
endinterface

// File: rtl/score_bcd_display_bcd_digit.sv
// Single decade counter; digits chain through CARRY_IN/CARRY_OUT.
module bcd_digit
  import score_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLEAR,
  input  logic             EN,
  input  logic             CARRY_IN,
  output logic [BCD_W-1:0] COUNT,
  output logic             CARRY_OUT
);

  always_ff @(posedge CLK) begin
    if (RESET || CLEAR) begin
      COUNT <= '0;
    end else if (EN && CARRY_IN) begin
      COUNT <= (COUNT == BCD_MAX) ? '0 : COUNT + 4'd1;
    end
  end

  assign CARRY_OUT = (COUNT == BCD_MAX) && CARRY_IN;

endmodule

// File: rtl/score_bcd_display.sv
// N-digit saturating BCD score with time-multiplexed digit output.
// Optional high-score register enabled by defining SCORE_HIGH_SCORE_EN.
module score_bcd_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int STROBE_MAX   = DEFAULT_STROBE_MAX,
  parameter int STROBE_WIDTH = DEFAULT_STROBE_WIDTH,
  parameter int SEL_WIDTH    = sel_width_for(NUM_DIGITS)
) (
  input logic CLK,
  input logic RESET,
  score_bcd_display_if.slave bus
);

  logic                    ate_q;
  logic                    inc;
  logic                    step_en;
  logic [NUM_DIGITS:0]     carry;
  logic [BCD_W-1:0]        digit [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] score_bcd;
  logic [STROBE_WIDTH-1:0] pre_q;
  logic                    tick;
  logic [SEL_WIDTH-1:0]    strobe_q;
  logic [4*NUM_DIGITS-1:0] shown_bcd;
  logic [BCD_W-1:0]        shown_digit;

  always_ff @(posedge CLK) begin
    if (RESET) ate_q <= 1'b0;
    else       ate_q <= bus.TARGET_ATE;
  end

  assign inc = bus.TARGET_ATE & ~ate_q;
  // carry[NUM_DIGITS] is high exactly when every digit is 9.
  assign step_en = inc & ~carry[NUM_DIGITS];
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .CLK       (CLK),
      .RESET     (RESET),
      .CLEAR     (bus.GAME_RESTART),
      .EN        (step_en),
      .CARRY_IN  (carry[g]),
      .COUNT     (digit[g]),
      .CARRY_OUT (carry[g+1])
    );
  end

  always_comb begin
    score_bcd = '0;
    for (int k = 0; k < NUM_DIGITS; k++) score_bcd[4*k +: 4] = digit[k];
  end

  always_ff @(posedge CLK) begin
    if (RESET)     pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end

  assign tick = (pre_q == STROBE_WIDTH'(STROBE_MAX));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      strobe_q <= '0;
    end else if (tick) begin
      if (strobe_q == SEL_WIDTH'(NUM_DIGITS - 1)) strobe_q <= '0;
      else                                        strobe_q <= strobe_q + 1'b1;
    end
  end

`ifdef SCORE_HIGH_SCORE_EN
  logic [4*NUM_DIGITS-1:0] high_q;

  // Packed BCD with the MSD on top compares correctly as a plain integer.
  always_ff @(posedge CLK) begin
    if (RESET)                                       high_q <= '0;
    else if (bus.GAME_RESTART && score_bcd > high_q) high_q <= score_bcd;
  end

  assign bus.HIGH_BCD = high_q;
  assign shown_bcd    = bus.SHOW_HIGH ? high_q : score_bcd;
`else
  assign shown_bcd = score_bcd;
`endif

  always_comb begin
    shown_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (strobe_q == SEL_WIDTH'(k)) shown_digit = shown_bcd[4*k +: 4];
    end
  end

  assign bus.STROBE_COUNT = strobe_q;
  assign bus.SCORE_COUNT  = shown_digit;
  assign bus.SCORE_BCD    = score_bcd;
  assign bus.SATURATED    = carry[NUM_DIGITS];

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display with a fast strobe (STROBE_MAX=3).
// Covers the high-score path when SCORE_HIGH_SCORE_EN is defined.
module tb_score_bcd_display;

  localparam int ND = 4;
  localparam int SW = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  score_bcd_display_if #(.NUM_DIGITS(ND), .SEL_WIDTH(SW)) bus ();

  score_bcd_display #(
    .NUM_DIGITS   (ND),
    .STROBE_MAX   (3),
    .STROBE_WIDTH (2),
    .SEL_WIDTH    (SW)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 time unit after posedge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.TARGET_ATE = 1'b1;
      step();
      bus.TARGET_ATE = 1'b0;
      step();
    end
  endtask

  task automatic restart();
    bus.GAME_RESTART = 1'b1;
    step();
    bus.GAME_RESTART = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // find the cycle right after the strobe wraps 3->0, then check one full rotation
  task automatic strobe_rotation(input string tag);
    logic [3:0]    exp_dig [4];
    logic [SW-1:0] prev;
    bit            found;
    exp_dig[0] = 4'd4; exp_dig[1] = 4'd3; exp_dig[2] = 4'd2; exp_dig[3] = 4'd1;
    found = 1'b0;
    prev  = bus.STROBE_COUNT;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (prev == 2'd3 && bus.STROBE_COUNT == 2'd0) found = 1'b1;
      else prev = bus.STROBE_COUNT;
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL %s_sync observed=no_wrap expected=wrap_within_40_cycles", tag);
    end
    if (found) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("%s_sel%0d", tag, i), 32'(bus.STROBE_COUNT), 32'(i % 4));
        check($sformatf("%s_dig%0d", tag, i), 32'(bus.SCORE_COUNT), 32'(exp_dig[i % 4]));
        step(2);
        check($sformatf("%s_hold%0d", tag, i), 32'(bus.STROBE_COUNT), 32'(i % 4));
        step(2);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.TARGET_ATE   = 1'b0;
    bus.GAME_RESTART = 1'b0;
`ifdef SCORE_HIGH_SCORE_EN
    bus.SHOW_HIGH = 1'b0;
`endif
    step(2);
    check("por_score", 32'(bus.SCORE_BCD), 32'h0);
    check("por_sel", 32'(bus.STROBE_COUNT), 32'h0);
    check("por_sat", 32'(bus.SATURATED), 32'h0);
    rst = 1'b0;

    // reset mid-count
    pulse(42);
    check("pre_reset_score", 32'(bus.SCORE_BCD), 32'h0042);
    step(1);
    rst = 1'b1;
    step(1);
    check("reset_1cyc_score", 32'(bus.SCORE_BCD), 32'h0);
    step(2);
    check("reset_score", 32'(bus.SCORE_BCD), 32'h0);
    check("reset_sel", 32'(bus.STROBE_COUNT), 32'h0);
    check("reset_sat", 32'(bus.SATURATED), 32'h0);
    check("reset_digit", 32'(bus.SCORE_COUNT), 32'h0);
    rst = 1'b0;

    // held level scores exactly once
    bus.TARGET_ATE = 1'b1;
    step(1);
    check("edge_first", 32'(bus.SCORE_BCD), 32'h0001);
    step(9);
    check("edge_held", 32'(bus.SCORE_BCD), 32'h0001);
    bus.TARGET_ATE = 1'b0;
    step(1);
    pulse(9);
    check("edge_nine", 32'(bus.SCORE_BCD), 32'h0010);

    // multi-digit carry in one cycle
    restart();
    step(1);
    check("restart_clear", 32'(bus.SCORE_BCD), 32'h0);
    pulse(999);
    check("carry_pre", 32'(bus.SCORE_BCD), 32'h0999);
    bus.TARGET_ATE = 1'b1;
    step(1);
    check("carry_1000", 32'(bus.SCORE_BCD), 32'h1000);
    bus.TARGET_ATE = 1'b0;
    step(1);

    // restart coincident with a rise drops the point; held level stays at 0
    bus.TARGET_ATE   = 1'b1;
    bus.GAME_RESTART = 1'b1;
    step(1);
    bus.GAME_RESTART = 1'b0;
    check("prio_clear", 32'(bus.SCORE_BCD), 32'h0);
    step(5);
    check("prio_held", 32'(bus.SCORE_BCD), 32'h0);
    bus.TARGET_ATE = 1'b0;
    step(1);

    // saturation
    pulse(9998);
    check("sat_pre_score", 32'(bus.SCORE_BCD), 32'h9998);
    check("sat_pre_flag", 32'(bus.SATURATED), 32'h0);
    pulse(1);
    check("sat_score", 32'(bus.SCORE_BCD), 32'h9999);
    check("sat_flag", 32'(bus.SATURATED), 32'h1);
    pulse(3);
    check("sat_hold", 32'(bus.SCORE_BCD), 32'h9999);
    restart();
    check("sat_restart_score", 32'(bus.SCORE_BCD), 32'h0);
    check("sat_restart_flag", 32'(bus.SATURATED), 32'h0);

    // strobe rotation from a clean reset at score 1234
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    pulse(1234);
    check("strobe_score", 32'(bus.SCORE_BCD), 32'h1234);
    strobe_rotation("strobe");

`ifdef SCORE_HIGH_SCORE_EN
    check("high_pre", 32'(bus.HIGH_BCD), 32'h0);
    restart();
    check("high_capture", 32'(bus.HIGH_BCD), 32'h1234);
    check("high_score_clr", 32'(bus.SCORE_BCD), 32'h0);
    pulse(5);
    restart();
    check("high_keep", 32'(bus.HIGH_BCD), 32'h1234);
    bus.SHOW_HIGH = 1'b1;
    strobe_rotation("high_strobe");
    bus.SHOW_HIGH = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
